// File: rtl/rib_dma.sv
`default_nettype none
// ============================================================================
// Module      : rib_dma
// Description : Single-channel 32-bit word-copy DMA; RIB master for data moves,
//               RIB slave for its CTRL/STATUS/SRC/DST/LEN registers.
// Revision    : 1.0 - initial release
// ============================================================================
module rib_dma #(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic [31:0] s_data_o,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_grant_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [2:0] C_OFF_CTRL   = 3'd0;
    localparam logic [2:0] C_OFF_STATUS = 3'd1;
    localparam logic [2:0] C_OFF_SRC    = 3'd2;
    localparam logic [2:0] C_OFF_DST    = 3'd3;
    localparam logic [2:0] C_OFF_LEN    = 3'd4;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        cur_src_q, cur_src_d;
    logic [31:0]        cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_q, buf_d;
    logic               irq_q, irq_d;

    logic               w_busy;
    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_start;
    logic               w_abort;
    logic               w_unused;

    assign w_unused  = ^{s_addr_i[31:5], s_addr_i[1:0]};
    assign w_busy    = (state_q != ST_IDLE);
    assign w_wr      = s_we_i && (s_sel_i == 4'hF);
    assign w_wr_ctrl = w_wr && (s_addr_i[4:2] == C_OFF_CTRL);
    // ABORT dominates START when both are written together.
    assign w_start   = w_wr_ctrl && s_data_i[0] && !s_data_i[2];
    assign w_abort   = w_wr_ctrl && s_data_i[2];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        irq_d     = done_q && irq_en_q;

        if (w_wr) begin
            case (s_addr_i[4:2])
                C_OFF_CTRL:   irq_en_d = s_data_i[1];
                C_OFF_STATUS: begin
                    if (s_data_i[1]) done_d = 1'b0;
                    if (s_data_i[2]) err_d  = 1'b0;
                end
                C_OFF_SRC:    if (!w_busy) src_d = s_data_i;
                C_OFF_DST:    if (!w_busy) dst_d = s_data_i;
                C_OFF_LEN:    if (!w_busy) len_d = s_data_i[LEN_W-1:0];
                default:      ;
            endcase
        end

        // Engine updates come after the clear above so a set always wins.
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    cur_src_d = src_q;
                    cur_dst_d = dst_q;
                    cnt_d     = len_q;
                    if ((src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (m_grant_i) begin
                    buf_d   = m_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (m_grant_i) begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        s_data_o = 32'd0;
        case (s_addr_i[4:2])
            C_OFF_CTRL:   s_data_o = {30'd0, irq_en_q, 1'b0};
            C_OFF_STATUS: s_data_o = {29'd0, err_q, done_q, w_busy};
            C_OFF_SRC:    s_data_o = src_q;
            C_OFF_DST:    s_data_o = dst_q;
            C_OFF_LEN:    s_data_o = 32'(len_q);
            default:      s_data_o = 32'd0;
        endcase
    end

    // Master outputs decode straight from state so reset drops them at once.
    always_comb begin
        m_req_o  = w_busy;
        m_we_o   = (state_q == ST_WRITE);
        m_sel_o  = w_busy ? 4'hF : 4'h0;
        m_addr_o = 32'd0;
        m_data_o = 32'd0;
        if (state_q == ST_READ) begin
            m_addr_o = cur_src_q;
        end else if (state_q == ST_WRITE) begin
            m_addr_o = cur_dst_q;
            m_data_o = buf_q;
        end
    end

    assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: doc/rib_dma.md
# rib_dma

Single-channel word-copy DMA engine that sits beside the RIB bus: it is a RIB master on master slot 2 and a RIB slave for its own registers on slave slot 5. Software programs source, destination and length through the slave port, then sets start. The engine copies 32-bit words memory-to-memory, one bus read and one bus write per word, and interrupts on completion. The top level derives `m_grant_i` from the RIB arbitration, because master 2 wins only when masters 3 and 0 are idle.

## Interface
Parameters:
- `LEN_W`, 16, width of the LEN register and the remaining-word counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `s_addr_i`  in  32  register address from the RIB slave slot; only bits [4:2] are decoded.
- `s_data_i`  in  32  register write data.
- `s_data_o`  out  32  register read data; combinational.
- `s_we_i`  in  1  register write strobe, level; a write takes effect at the clock edge.
- `s_sel_i`  in  4  byte select; a register write takes effect only when this is 4'hF.
- `m_addr_o`  out  32  bus address to the RIB master slot.
- `m_data_o`  out  32  bus write data.
- `m_data_i`  in  32  bus read data; combinational, valid in the same cycle.
- `m_req_o`  out  1  bus request.
- `m_we_o`  out  1  bus write flag.
- `m_sel_o`  out  4  byte select; 4'hF during every access.
- `m_grant_i`  in  1  high when RIB is currently routing master 2 (m2_req & ~m3_req & ~m0_req).
- `irq_o`  out  1  completion interrupt, registered.

## Operation
Register map (offset = `s_addr_i`[4:0]):
- 0x00 CTRL:
  - bit0 START, write-1 pulse, reads 0.
  - bit1 IRQ_EN, read/write.
  - bit2 ABORT, write-1 pulse, reads 0.
- 0x04 STATUS:
  - bit0 BUSY, read-only.
  - bit1 DONE, write-1 clears.
  - bit2 ERR, write-1 clears.
- 0x08 SRC, 0x0C DST, 0x10 LEN: read/write.
  - LEN holds a word count and occupies the low `LEN_W` bits.
  - While BUSY, writes to these three registers are ignored.
- Any other offset reads 0; writes there are ignored.

State machine IDLE -> READ -> WRITE -> (READ | IDLE):
- START in IDLE loads `cur_src`=SRC, `cur_dst`=DST, `cnt`=LEN. Exactly one of the following applies:
  - If SRC[1:0] or DST[1:0] is nonzero, ERR is set and the engine stays IDLE.
  - Otherwise, if LEN==0, DONE is set and the engine stays IDLE with no bus traffic.
  - Otherwise the engine goes to READ.
- START while BUSY is ignored.
- READ drives `m_req_o`=1, `m_we_o`=0, `m_addr_o`=`cur_src`.
  - On an edge with `m_grant_i`=1: capture `m_data_i` into `buf` and go to WRITE.
  - Otherwise hold READ.
- WRITE drives `m_req_o`=1, `m_we_o`=1, `m_addr_o`=`cur_dst`, `m_data_o`=`buf`.
  - On an edge with grant: `cur_src`+=4, `cur_dst`+=4 (mod 2^32), `cnt`-=1.
  - If `cnt` was 1, set DONE and go to IDLE; otherwise go to READ.
- ABORT while BUSY moves the engine to IDLE at the next edge.
  - The granted access in that cycle (if any) is still accepted by the slave.
  - `cnt` is frozen, and DONE and ERR are unchanged.
- IDLE drives `m_req_o`=0, `m_we_o`=0, `m_addr_o`=0, `m_data_o`=0.
- BUSY = (state != IDLE).
- `irq_o` register loads DONE & IRQ_EN every cycle.
- Simultaneous DONE set and write-1-clear in the same cycle: set wins. The same rule applies to ERR.
- Simultaneous START and ABORT in one write: ABORT wins and no transfer starts.

## Timing
- Reset state:
  - All registers, `buf`, `cnt` and `irq_o` are 0; state is IDLE.
  - `m_req_o`, `m_we_o`, `m_addr_o`, `m_data_o` and `m_sel_o` are all 0.
  - Reset asserted mid-transfer clears everything immediately; `m_req_o` drops asynchronously.
- Start latency:
  - BUSY and `m_req_o` rise in the cycle after the START write edge.
  - ERR or DONE for a rejected or zero-length start is visible in that same cycle.
- Throughput: with `m_grant_i` held at 1, N words take exactly 2N cycles from the first READ cycle to IDLE.
- Completion: DONE is set at the edge that ends the last WRITE; `irq_o` rises one cycle later.
- Slave port:
  - `s_data_o` is combinational from the registers.
  - A write is visible on readback in the following cycle.
- Grant low: the master outputs hold stable for any number of cycles until the grant edge.

## Test plan
- Basic copy:
  - Stimulus: SRC=0x1000_0000, DST=0x1000_0100, LEN=4, IRQ_EN=1, START, grant tied high.
  - Required: 8 bus cycles alternating read/write, destination words equal source, DONE=1, `irq_o` high 1 cycle after BUSY falls.
- Grant stall:
  - Stimulus: LEN=2; drop `m_grant_i` for 3 cycles during the first WRITE.
  - Required: `m_addr_o`/`m_data_o`/`m_we_o` hold stable, total 7 cycles, data correct.
- Edge starts:
  - Stimulus: start with LEN=0.
  - Required: DONE next cycle, `m_req_o` never high.
  - Stimulus: start with SRC=0x1000_0002.
  - Required: ERR=1, BUSY=0.
- Abort and register lock:
  - Stimulus: LEN=8; ABORT after 3 words; then write LEN=5 while BUSY (before the abort).
  - Required: IDLE next cycle, DONE=0, LEN reads 8, destination words 0-2 written and word 3 untouched.
- Clear/set collision and restart:
  - Stimulus: write STATUS=0x2 on the edge where the last WRITE completes; then issue START while BUSY.
  - Required: DONE reads 1; the START while BUSY does not reload `cnt`.
- Async reset mid-transfer:
  - Stimulus: assert `rst` low during a READ cycle.
  - Required: `m_req_o`=0 immediately; all registers read 0 after release.
